// File: rtl/issue_pkg.sv
// Shared fetch/decode definitions: queue entry type, NOP and branch opcodes.
// Used by the issue pair aligner and the decode dependency checker.
package issue_pkg;

    localparam int IQ_DATA_W = 32;
    localparam int IQ_PC_W   = 32;

    typedef struct packed {
        logic [IQ_DATA_W-1:0] inst;
        logic [IQ_PC_W-1:0]   pc;
    } iq_entry_t;

    localparam logic [IQ_DATA_W-1:0] NOP_INST = 32'h0;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

endpackage

// File: rtl/iq_storage.sv
// Instruction queue register file: two write ports at tail/tail+1,
// two read ports at head/head+1; pointer control lives in the parent.
module iq_storage
    import issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we0,
    input  logic [$clog2(DEPTH)-1:0] waddr0,
    input  iq_entry_t                wdata0,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] waddr1,
    input  iq_entry_t                wdata1,
    input  logic [$clog2(DEPTH)-1:0] raddr0,
    output iq_entry_t                rdata0,
    input  logic [$clog2(DEPTH)-1:0] raddr1,
    output iq_entry_t                rdata1
);

    iq_entry_t mem_q [DEPTH];

    // Entry writes; the two ports always target distinct slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (we0) mem_q[waddr0] <= wdata0;
            if (we1) mem_q[waddr1] <= wdata1;
        end
    end

    assign rdata0 = mem_q[raddr0];
    assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/issue_pair_aligner.sv
// Fetch queue presenting the two oldest words as a decode issue pair.
// Optional perf counters enabled by defining ISSUE_PERF_CNT_EN.
module issue_pair_aligner
    import issue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = IQ_DATA_W,
    parameter int PC_W   = IQ_PC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        fetch_valid,
    input  logic [DATA_W-1:0] fetch_inst0,
    input  logic [DATA_W-1:0] fetch_inst1,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              fetch_ready,
    output logic [DATA_W-1:0] inst1_D,
    output logic [DATA_W-1:0] inst2_D,
    output logic [PC_W-1:0]   pc1_D,
    output logic [PC_W-1:0]   pc2_D,
    output logic              valid1_D,
    output logic              valid2_D,
`ifdef ISSUE_PERF_CNT_EN
    output logic [31:0]       perf_dual,
    output logic [31:0]       perf_single,
    output logic [31:0]       perf_empty,
`endif
    input  logic              dec_stall,
    input  logic              pair_stall,
    input  logic              flush_inst2,
    input  logic              redirect
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic [CNT_W-1:0] pop_n;
    logic [CNT_W-1:0] push_n;
    logic             push_ok;
    logic             clear;
    logic             take_flush;

    iq_entry_t wdata0;
    iq_entry_t wdata1;
    iq_entry_t rdata0;
    iq_entry_t rdata1;

    logic [PC_W-1:0] pc_next;

    assign valid1_D    = (count_q != '0);
    assign valid2_D    = (count_q >= CNT_W'(2));
    assign fetch_ready = ((CNT_W'(DEPTH) - count_q) >= CNT_W'(2));
    assign take_flush  = flush_inst2 && valid1_D;
    assign pc_next     = fetch_pc + PC_W'(1);

    // Pop selection: redirect > stall > branch squash > pair hazard > normal
    always_comb begin
        pop_n   = '0;
        push_ok = 1'b0;
        clear   = 1'b0;
        priority case (1'b1)
            redirect: begin
                clear = 1'b1;
            end
            dec_stall: begin
                push_ok = 1'b1;
            end
            take_flush: begin
                clear = 1'b1;
                pop_n = CNT_W'(1);
            end
            pair_stall: begin
                push_ok = 1'b1;
                pop_n   = CNT_W'(valid1_D);
            end
            default: begin
                push_ok = 1'b1;
                pop_n   = CNT_W'(valid1_D) + CNT_W'(valid2_D);
            end
        endcase
    end

    // Compact valid fetch words onto the tail in program order
    always_comb begin
        push_n = '0;
        wdata0 = '{inst: fetch_inst0, pc: fetch_pc};
        wdata1 = '{inst: fetch_inst1, pc: pc_next};
        if (!fetch_valid[0]) begin
            wdata0 = '{inst: fetch_inst1, pc: pc_next};
        end
        if (push_ok && fetch_ready && (fetch_valid != 2'b00)) begin
            push_n = (fetch_valid == 2'b11) ? CNT_W'(2) : CNT_W'(1);
        end
    end

    iq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk    (clk),
        .rst_n  (rst_n),
        .we0    (push_n != '0),
        .waddr0 (tail_q),
        .wdata0 (wdata0),
        .we1    (push_n == CNT_W'(2)),
        .waddr1 (tail_q + PTR_W'(1)),
        .wdata1 (wdata1),
        .raddr0 (head_q),
        .rdata0 (rdata0),
        .raddr1 (head_q + PTR_W'(1)),
        .rdata1 (rdata1)
    );

    // Head/tail/count bookkeeping; a clear drops everything queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (clear) begin
            head_q  <= tail_q;
            count_q <= '0;
        end else begin
            head_q  <= head_q + pop_n[PTR_W-1:0];
            tail_q  <= tail_q + push_n[PTR_W-1:0];
            count_q <= count_q + push_n - pop_n;
        end
    end

    assign inst1_D = valid1_D ? rdata0.inst : NOP_INST;
    assign inst2_D = valid2_D ? rdata1.inst : NOP_INST;
    assign pc1_D   = valid1_D ? rdata0.pc : '0;
    assign pc2_D   = valid2_D ? rdata1.pc : '0;

`ifdef ISSUE_PERF_CNT_EN
    // Saturating issue-width counters, frozen while decode is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_dual   <= '0;
            perf_single <= '0;
            perf_empty  <= '0;
        end else if (!(dec_stall || redirect)) begin
            if (pop_n == CNT_W'(2) && perf_dual != '1) begin
                perf_dual <= perf_dual + 32'd1;
            end
            if (pop_n == CNT_W'(1) && perf_single != '1) begin
                perf_single <= perf_single + 32'd1;
            end
            if (count_q == '0 && perf_empty != '1) begin
                perf_empty <= perf_empty + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_issue_pair_aligner.sv
// Directed bench for issue_pair_aligner with a queue-based reference model.
// Literal checks pin key scenarios; the model is compared every cycle.
module tb_issue_pair_aligner;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  fetch_valid;
    logic [31:0] fetch_inst0;
    logic [31:0] fetch_inst1;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic [31:0] inst1_D;
    logic [31:0] inst2_D;
    logic [31:0] pc1_D;
    logic [31:0] pc2_D;
    logic        valid1_D;
    logic        valid2_D;
    logic        dec_stall;
    logic        pair_stall;
    logic        flush_inst2;
    logic        redirect;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t mq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    issue_pair_aligner #(.DEPTH(DEPTH), .DATA_W(32), .PC_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_valid (fetch_valid),
        .fetch_inst0 (fetch_inst0),
        .fetch_inst1 (fetch_inst1),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .inst1_D     (inst1_D),
        .inst2_D     (inst2_D),
        .pc1_D       (pc1_D),
        .pc2_D       (pc2_D),
        .valid1_D    (valid1_D),
        .valid2_D    (valid2_D),
        .dec_stall   (dec_stall),
        .pair_stall  (pair_stall),
        .flush_inst2 (flush_inst2),
        .redirect    (redirect)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic compare_model();
        int n;
        logic [31:0] e_i1, e_i2, e_p1, e_p2;
        n = mq.size();
        e_i1 = 0; e_i2 = 0; e_p1 = 0; e_p2 = 0;
        if (n >= 1) begin
            e_i1 = mq[0].inst;
            e_p1 = mq[0].pc;
        end
        if (n >= 2) begin
            e_i2 = mq[1].inst;
            e_p2 = mq[1].pc;
        end
        check("m_valid1", {31'b0, valid1_D}, {31'b0, n >= 1});
        check("m_valid2", {31'b0, valid2_D}, {31'b0, n >= 2});
        check("m_ready", {31'b0, fetch_ready}, {31'b0, (DEPTH - n) >= 2});
        check("m_inst1", inst1_D, e_i1);
        check("m_inst2", inst2_D, e_i2);
        check("m_pc1", pc1_D, e_p1);
        check("m_pc2", pc2_D, e_p2);
    endtask

    task automatic model_step();
        int  n;
        int  pop;
        bit  ready;
        bit  take_push;
        n = mq.size();
        ready = (DEPTH - n) >= 2;
        take_push = 1'b1;
        pop = 0;
        if (redirect) begin
            mq.delete();
            take_push = 1'b0;
        end else if (dec_stall) begin
            pop = 0;
        end else if (flush_inst2 && n >= 1) begin
            mq.delete();
            take_push = 1'b0;
        end else if (pair_stall) begin
            pop = (n >= 1) ? 1 : 0;
        end else begin
            pop = (n >= 2) ? 2 : n;
        end
        repeat (pop) void'(mq.pop_front());
        if (take_push && ready) begin
            if (fetch_valid[0]) mq.push_back('{fetch_inst0, fetch_pc});
            if (fetch_valid[1]) mq.push_back('{fetch_inst1, fetch_pc + 1});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_valid = 2'b00;
        dec_stall   = 1'b0;
        pair_stall  = 1'b0;
        flush_inst2 = 1'b0;
        redirect    = 1'b0;
    endtask

    task automatic fetch(input logic [1:0] fv, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [31:0] pc);
        fetch_valid = fv;
        fetch_inst0 = i0;
        fetch_inst1 = i1;
        fetch_pc    = pc;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        fetch(2'b00, 0, 0, 0);
        #1;
        check("rst_valid1", {31'b0, valid1_D}, 0);
        check("rst_valid2", {31'b0, valid2_D}, 0);
        check("rst_ready", {31'b0, fetch_ready}, 1);
        check("rst_inst1", inst1_D, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic pair push then dual issue
        fetch(2'b11, 32'hA, 32'hB, 32'h10);
        tick();
        idle();
        check("t1_valid1", {31'b0, valid1_D}, 1);
        check("t1_valid2", {31'b0, valid2_D}, 1);
        check("t1_pc1", pc1_D, 32'h10);
        check("t1_pc2", pc2_D, 32'h11);
        check("t1_inst1", inst1_D, 32'hA);
        tick();
        check("t1_empty", {31'b0, valid1_D}, 0);

        // Fill to four, then one pair-stall cycle
        fetch(2'b11, 32'hA1, 32'hB1, 32'h30);
        tick();
        dec_stall = 1'b1;
        fetch(2'b11, 32'hC1, 32'hD1, 32'h32);
        tick();
        idle();
        check("t2_full_ready", {31'b0, fetch_ready}, 0);
        pair_stall = 1'b1;
        tick();
        idle();
        check("t2_inst1", inst1_D, 32'hB1);
        check("t2_inst2", inst2_D, 32'hC1);
        check("t2_pc1", pc1_D, 32'h31);
        check("t2_ready3", {31'b0, fetch_ready}, 0);
        tick();
        check("t2_ready1", {31'b0, fetch_ready}, 1);
        check("t2_last", inst1_D, 32'hD1);
        tick();

        // Branch squash with three queued and a concurrent fetch
        fetch(2'b11, 32'h1, 32'h2, 32'h50);
        tick();
        idle();
        dec_stall = 1'b1;
        fetch(2'b01, 32'h3, 32'h0, 32'h52);
        tick();
        idle();
        flush_inst2 = 1'b1;
        fetch(2'b11, 32'h77, 32'h78, 32'h53);
        tick();
        idle();
        check("t3_valid1", {31'b0, valid1_D}, 0);

        // Squash with room available: wrong-path push must still drop
        fetch(2'b11, 32'h4, 32'h5, 32'h60);
        tick();
        idle();
        flush_inst2 = 1'b1;
        pair_stall  = 1'b1;
        fetch(2'b11, 32'h66, 32'h67, 32'h62);
        tick();
        idle();
        check("t3b_valid1", {31'b0, valid1_D}, 0);

        // Global stall for three cycles while fetch keeps pushing
        fetch(2'b11, 32'hAA, 32'hBB, 32'h70);
        tick();
        for (int i = 0; i < 3; i++) begin
            dec_stall = 1'b1;
            fetch(2'b11, 32'hC0 + i, 32'hD0 + i, 32'h72 + 2 * i);
            tick();
        end
        idle();
        check("t4_inst1", inst1_D, 32'hAA);
        check("t4_inst2", inst2_D, 32'hBB);
        check("t4_ready", {31'b0, fetch_ready}, 0);
        tick();
        check("t4_next", inst1_D, 32'hC0);
        check("t4_next_pc", pc2_D, 32'h73);
        tick();

        // Only the upper fetch word valid
        fetch(2'b10, 32'h11, 32'h22, 32'h20);
        tick();
        idle();
        check("t5_pc1", pc1_D, 32'h21);
        check("t5_inst1", inst1_D, 32'h22);
        check("t5_valid2", {31'b0, valid2_D}, 0);
        tick();

        // Redirect beats stall and push, queue holding three
        fetch(2'b11, 32'h31, 32'h32, 32'h80);
        tick();
        idle();
        dec_stall = 1'b1;
        fetch(2'b01, 32'h33, 32'h0, 32'h82);
        tick();
        idle();
        redirect  = 1'b1;
        dec_stall = 1'b1;
        fetch(2'b11, 32'h44, 32'h45, 32'h90);
        tick();
        idle();
        check("t6_valid1", {31'b0, valid1_D}, 0);
        check("t6_ready", {31'b0, fetch_ready}, 1);
        fetch(2'b01, 32'hE, 32'h0, 32'h50);
        tick();
        idle();
        check("t6_after", inst1_D, 32'hE);

        // Asynchronous reset mid-stream
        fetch(2'b11, 32'h5A, 32'h5B, 32'hA0);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        mq.delete();
        check("t7_valid1", {31'b0, valid1_D}, 0);
        check("t7_valid2", {31'b0, valid2_D}, 0);
        check("t7_inst1", inst1_D, 0);
        check("t7_ready", {31'b0, fetch_ready}, 1);
        #1;
        rst_n = 1'b1;

        // Walk head to DEPTH-1 so slot2 reads index 0
        for (int i = 0; i < DEPTH - 1; i++) begin
            fetch(2'b01, 32'hF0 + i, 32'h0, 32'hB0 + i);
            tick();
            idle();
            tick();
        end
        fetch(2'b11, 32'hCAFE, 32'hBEEF, 32'h40);
        tick();
        idle();
        check("t8_inst1", inst1_D, 32'hCAFE);
        check("t8_inst2", inst2_D, 32'hBEEF);
        check("t8_pc2", pc2_D, 32'h41);
        tick();

        // Mixed control table exercising wraps and priorities
        for (int i = 0; i < 48; i++) begin
            fetch_valid = 2'(i % 4);
            fetch_inst0 = 32'h1000 + 32'(i);
            fetch_inst1 = 32'h2000 + 32'(i);
            fetch_pc    = 32'h100 + 32'(2 * i);
            dec_stall   = (i % 5) == 0;
            pair_stall  = (i % 3) == 1;
            flush_inst2 = (i % 11) == 7;
            redirect    = (i % 13) == 12;
            tick();
        end
        idle();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
